pc_source_ctrl: RTL and testbench
=================================

# pc_source_ctrl

Sequencer for the PC-update path of the multicycle CPU. Accepts one PC-update request per instruction from the main control unit, resolves branch conditions and exception vector fetches, and drives the PC source select, PC write enable and EPC write enable. It sits between the main control FSM and the PC source mux, PC register and EPC register.

## Interface
- MEM_LAT, 2, cycles the vector-table memory read needs before its data is valid (≥1)
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  request strobe from main control, sampled only in IDLE
- req_op  in  3  0=NEXT, 1=BEQ, 2=BNE, 3=J, 4=JR, 5=EXC, 6/7 illegal
- exc_cause  in  2  exception cause for EXC: 0=opcode, 1=overflow, 2=div0, 3=reserved
- zero  in  1  ALU zero flag, sampled in BR_EVAL
- stall  in  1  memory wait, extends VEC_RD
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the final cycle of a request
- pc_src  out  3  mux select: 0=PC+4, 1=ALUOut branch target, 2=jump target, 3=register (JR), 4=exception vector byte
- pc_write  out  1  PC register load enable
- epc_write  out  1  EPC register load enable
- mem_rd  out  1  vector-table read enable
- vec_sel  out  2  vector-table address select, equals latched cause

## Operation
- States: IDLE, BR_EVAL, EPC_SAVE, VEC_RD, WRITE, FINISH. Moore outputs decoded from registered state plus latched op/cause/src registers.
- IDLE, req=1: latch op, cause, and target source; NEXT→WRITE(src 0), J→WRITE(src 2), JR→WRITE(src 3), BEQ/BNE→BR_EVAL, EXC→EPC_SAVE. req=0: stay.
- Illegal op 6/7: handled as EXC with cause forced to 0.
- BR_EVAL: BEQ taken iff zero=1, BNE taken iff zero=0; taken→WRITE(src 1), not taken→FINISH.
- EPC_SAVE: epc_write=1 for one cycle → VEC_RD; wait counter loaded with MEM_LAT-1.
- VEC_RD: mem_rd=1, vec_sel=cause; counter decrements when stall=0, holds when stall=1; leaves to WRITE(src 4) when counter=0 and stall=0.
- WRITE: pc_write=1, done=1 → IDLE.
- FINISH: done=1, pc_write=0 → IDLE.
- pc_src holds the latched value from acceptance until the next acceptance; it does not change in IDLE.
- req while busy is ignored; the master must keep req low until done.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, pc_src=0, pc_write=0, epc_write=0, mem_rd=0, vec_sel=0, counter=0. Release mid-request discards it, with no partial PC write.
- Request accepted at edge k. NEXT/J/JR: WRITE in cycle k+1 (latency 1). Branch: BR_EVAL k+1, WRITE or FINISH k+2.
- EXC: EPC_SAVE k+1, VEC_RD k+2 … k+1+MEM_LAT+(stall cycles), WRITE in the following cycle.
- MEM_LAT=1: VEC_RD lasts exactly one cycle when stall=0.
- done and pc_write are never high for more than one consecutive cycle. epc_write and pc_write are never high together.
- stall is ignored outside VEC_RD.

## Structure
- Shared package or include holds the op codes (OP_NEXT…OP_EXC), pc_src codes (SRC_PC4…SRC_VEC), cause codes and state encodings, for common use by the main control unit.
- Single module. The VEC_RD wait counter stays inline (width clog2(MEM_LAT)+1); no sub-module.

## Test plan
- Reset mid-VEC_RD (assert reset_n=0) → all outputs 0 immediately; next req op 0 → pc_write/done pulse at k+1, pc_src=0.
- BEQ with zero=1 → BR_EVAL k+1, WRITE k+2 with pc_src=1. BEQ with zero=0 → FINISH k+2 with done=1 and pc_write=0. BNE mirrored.
- J and JR back-to-back (req reasserted the cycle after done) → pc_src 2 then 3, one pc_write each, 2 cycles apart.
- EXC cause=2, MEM_LAT=2, stall high 3 cycles in VEC_RD → epc_write at k+1, mem_rd with vec_sel=2 for 5 cycles, pc_write with pc_src=4 at k+7.
- req_op=7 → same sequence as EXC with vec_sel=0.
- req toggled while busy (during BR_EVAL and VEC_RD) → no effect on sequence, exactly one done per accepted request.

Source files
------------

// File: rtl/pc_source_ctrl_pkg.sv
// pc_source_ctrl_pkg
//   Codes shared between the main control unit and the PC-update sequencer:
//   request op codes, PC source mux selects, exception cause codes and the
//   sequencer state encoding.
package pc_source_ctrl_pkg;

  // Request op codes (req_op). Values 6 and 7 are illegal.
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_J    = 3'd3;
  localparam logic [2:0] OP_JR   = 3'd4;
  localparam logic [2:0] OP_EXC  = 3'd5;

  // PC source mux selects (pc_src).
  localparam logic [2:0] SRC_PC4 = 3'd0;
  localparam logic [2:0] SRC_ALU = 3'd1;
  localparam logic [2:0] SRC_JMP = 3'd2;
  localparam logic [2:0] SRC_REG = 3'd3;
  localparam logic [2:0] SRC_VEC = 3'd4;

  // Exception causes (exc_cause / vec_sel).
  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_DIV0   = 2'd2;
  localparam logic [1:0] CAUSE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BR_EVAL  = 3'd1,
    ST_EPC_SAVE = 3'd2,
    ST_VEC_RD   = 3'd3,
    ST_WRITE    = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

endpackage

// File: rtl/pc_source_ctrl.sv
// pc_source_ctrl
//   Sequences one PC update per instruction: resolves branches, saves EPC and
//   waits on the exception vector-table read, then pulses the PC write.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   req        request strobe, sampled only when idle
//   req_op     requested PC update (OP_* codes; 6/7 treated as opcode exception)
//   exc_cause  exception cause for OP_EXC
//   zero       ALU zero flag, used while evaluating a branch
//   stall      vector-table memory wait, only observed during the vector read
//   busy       high whenever a request is in progress
//   done       one-cycle pulse on the final cycle of a request
//   pc_src     PC source mux select, held from acceptance to next acceptance
//   pc_write   PC register load enable
//   epc_write  EPC register load enable
//   mem_rd     vector-table read enable
//   vec_sel    vector-table address select (latched cause)
module pc_source_ctrl
  import pc_source_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [2:0] req_op,
  input  logic [1:0] exc_cause,
  input  logic       zero,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic [2:0] pc_src,
  output logic       pc_write,
  output logic       epc_write,
  output logic       mem_rd,
  output logic [1:0] vec_sel
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    cause_q, cause_d;
  logic [2:0]    src_q, src_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and latched request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NEXT;
      cause_q <= CAUSE_OPCODE;
      src_q   <= SRC_PC4;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, including the latched request fields and wait counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d    = req_op;
          cause_d = exc_cause;
          unique case (req_op)
            OP_NEXT: begin src_d = SRC_PC4; state_d = ST_WRITE;    end
            OP_J:    begin src_d = SRC_JMP; state_d = ST_WRITE;    end
            OP_JR:   begin src_d = SRC_REG; state_d = ST_WRITE;    end
            OP_BEQ,
            OP_BNE:  begin src_d = SRC_ALU; state_d = ST_BR_EVAL;  end
            OP_EXC:  begin src_d = SRC_VEC; state_d = ST_EPC_SAVE; end
            default: begin
              // Illegal op: take the opcode exception vector.
              op_d    = OP_EXC;
              cause_d = CAUSE_OPCODE;
              src_d   = SRC_VEC;
              state_d = ST_EPC_SAVE;
            end
          endcase
        end
      end
      ST_BR_EVAL: begin
        // BEQ is taken on zero, BNE on not-zero.
        if ((op_q == OP_BEQ) ? zero : !zero) state_d = ST_WRITE;
        else                                 state_d = ST_FINISH;
      end
      ST_EPC_SAVE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_VEC_RD;
      end
      ST_VEC_RD: begin
        // A stalled cycle neither counts down nor allows leaving.
        if (!stall) begin
          if (cnt_q == '0) state_d = ST_WRITE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_WRITE:  state_d = ST_IDLE;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs from registered state and latched fields.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_WRITE) || (state_q == ST_FINISH);
    pc_write  = (state_q == ST_WRITE);
    epc_write = (state_q == ST_EPC_SAVE);
    mem_rd    = (state_q == ST_VEC_RD);
    pc_src    = src_q;
    vec_sel   = cause_q;
  end

endmodule

// File: tb/tb_pc_source_ctrl.sv
module tb_pc_source_ctrl;

  localparam int MEM_LAT = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req;
  logic [2:0] req_op;
  logic [1:0] exc_cause;
  logic       zero;
  logic       stall;
  logic       busy, done, pc_write, epc_write, mem_rd;
  logic [2:0] pc_src;
  logic [1:0] vec_sel;

  pc_source_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op),
    .exc_cause(exc_cause), .zero(zero), .stall(stall),
    .busy(busy), .done(done), .pc_src(pc_src), .pc_write(pc_write),
    .epc_write(epc_write), .mem_rd(mem_rd), .vec_sel(vec_sel)
  );

  always #5 clk = ~clk;

  // One expected output cycle plus the inputs the bench drives in that cycle.
  typedef struct packed {
    logic       busy, done, pw, epc, mr;
    logic [2:0] src;
    logic [1:0] vs;
    logic       st, z;
  } ent_t;

  ent_t exp_q[int];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   model_on = 0;
  logic [2:0] last_src = 3'd0;

  // Observed-event monitors used by the literal checks.
  int pw_cnt, done_cnt, epc_cnt, mr_cnt, pw_cyc, epc_cyc;
  logic [2:0] pw_src;
  logic [1:0] mr_vs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic lit(input string name, input int act, input int want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic clr_mon();
    pw_cnt = 0; done_cnt = 0; epc_cnt = 0; mr_cnt = 0;
    pw_cyc = -1; epc_cyc = -1; pw_src = 3'd7; mr_vs = 2'd3;
  endtask

  // Per-cycle compare against the model's expected sequence.
  always @(negedge clk) begin
    if (model_on && reset_n) begin
      logic [7:0] act, want;
      ent_t e;
      act = {busy, done, pc_write, epc_write, mem_rd, pc_src};
      if (exp_q.exists(cyc)) begin
        e = exp_q[cyc];
        exp_q.delete(cyc);
        want = {e.busy, e.done, e.pw, e.epc, e.mr, e.src};
        last_src = e.src;
      end else begin
        e = '0;
        want = {5'b0, last_src};
      end
      n_checks++;
      if (act !== want) begin
        n_fail++;
        $display("FAIL cycle %0d outputs {busy,done,pw,epc,mr,src}: got %b expected %b",
                 cyc, act, want);
      end
      if (e.mr) begin
        n_checks++;
        if (vec_sel !== e.vs) begin
          n_fail++;
          $display("FAIL cycle %0d vec_sel: got %0d expected %0d", cyc, vec_sel, e.vs);
        end
      end
      if (pc_write) begin pw_cnt++; pw_cyc = cyc; pw_src = pc_src; end
      if (done) done_cnt++;
      if (epc_write) begin epc_cnt++; epc_cyc = cyc; end
      if (mem_rd) begin mr_cnt++; mr_vs = vec_sel; end
    end
  end

  function automatic ent_t mk(input logic d, pw, epc, mr, input logic [2:0] src,
                              input logic [1:0] vs);
    ent_t e;
    e = '0;
    e.busy = 1'b1; e.done = d; e.pw = pw; e.epc = epc; e.mr = mr;
    e.src = src; e.vs = vs;
    return e;
  endfunction

  // Issue one request; k returns the cycle in which req was high (acceptance
  // at the end of it). stall_n = number of leading stalled vector-read cycles;
  // noise toggles req and drives stray stall/zero while busy.
  task automatic do_req(input logic [2:0] op, input logic [1:0] cause, input logic zv,
                        input int stall_n, input bit noise, output int k);
    ent_t seq[$];
    logic [2:0] eop;
    logic [1:0] ecause;
    bit taken;
    eop = op; ecause = cause;
    if (op > 3'd5) begin eop = 3'd5; ecause = 2'd0; end
    case (eop)
      3'd0: seq.push_back(mk(1, 1, 0, 0, 3'd0, 0));
      3'd3: seq.push_back(mk(1, 1, 0, 0, 3'd2, 0));
      3'd4: seq.push_back(mk(1, 1, 0, 0, 3'd3, 0));
      3'd1, 3'd2: begin
        taken = (eop == 3'd1) ? zv : !zv;
        seq.push_back(mk(0, 0, 0, 0, 3'd1, 0));
        seq[0].z = zv;
        seq.push_back(mk(1, taken, 0, 0, 3'd1, 0));
      end
      default: begin
        seq.push_back(mk(0, 0, 1, 0, 3'd4, 0));
        for (int i = 0; i < MEM_LAT + stall_n; i++) begin
          ent_t e;
          e = mk(0, 0, 0, 1, 3'd4, ecause);
          e.st = (i < stall_n);
          seq.push_back(e);
        end
        seq.push_back(mk(1, 1, 0, 0, 3'd4, 0));
      end
    endcase
    // Stray stall/zero outside the cycles where they matter.
    foreach (seq[j]) begin
      if (noise && !seq[j].mr) seq[j].st = 1'b1;
      if (noise && !(eop inside {3'd1, 3'd2} && j == 0)) seq[j].z = ~zv;
    end
    k = cyc;
    req = 1'b1; req_op = op; exc_cause = cause; zero = 1'b0; stall = 1'b0;
    foreach (seq[j]) exp_q[k + 1 + j] = seq[j];
    foreach (seq[j]) begin
      @(posedge clk); #1;
      stall  = seq[j].st;
      zero   = seq[j].z;
      req    = noise && (j != seq.size() - 1) && (j % 2 == 0);
      req_op = 3'($urandom_range(0, 7));
      exc_cause = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    req = 1'b0; stall = 1'b0; zero = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, prev_pw;
    reset_n = 1'b0; req = 1'b0; req_op = 3'd0; exc_cause = 2'd0;
    zero = 1'b0; stall = 1'b0;
    clr_mon();
    #12;
    lit("reset busy", busy, 0);
    lit("reset done", done, 0);
    lit("reset pc_src", pc_src, 0);
    lit("reset pc_write", pc_write, 0);
    lit("reset epc_write", epc_write, 0);
    lit("reset mem_rd", mem_rd, 0);
    lit("reset vec_sel", vec_sel, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Exception interrupted by reset while reading the vector table.
    req = 1'b1; req_op = 3'd5; exc_cause = 2'd1;
    @(posedge clk); #1; req = 1'b0;           // EPC_SAVE
    @(posedge clk); #1;                       // VEC_RD
    lit("pre-reset mem_rd", mem_rd, 1);
    #2 reset_n = 1'b0;
    #1;
    lit("midreset busy", busy, 0);
    lit("midreset mem_rd", mem_rd, 0);
    lit("midreset vec_sel", vec_sel, 0);
    lit("midreset pc_src", pc_src, 0);
    lit("midreset pc_write", pc_write, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    last_src = 3'd0;
    model_on = 1;
    @(posedge clk); #1;

    // NEXT after reset.
    clr_mon();
    do_req(3'd0, 2'd0, 0, 0, 0, k);
    lit("next pw_cyc", pw_cyc - k, 1);
    lit("next pc_src", pw_src, 0);
    lit("next done", done_cnt, 1);

    // Branches.
    clr_mon();
    do_req(3'd1, 2'd0, 1, 0, 0, k);
    lit("beq z1 pw_cyc", pw_cyc - k, 2);
    lit("beq z1 pc_src", pw_src, 1);
    clr_mon();
    do_req(3'd1, 2'd0, 0, 0, 0, k);
    lit("beq z0 pw", pw_cnt, 0);
    lit("beq z0 done", done_cnt, 1);
    clr_mon();
    do_req(3'd2, 2'd0, 0, 0, 0, k);
    lit("bne z0 pw", pw_cnt, 1);
    clr_mon();
    do_req(3'd2, 2'd0, 1, 0, 0, k);
    lit("bne z1 pw", pw_cnt, 0);
    lit("bne z1 done", done_cnt, 1);

    // J then JR back-to-back.
    clr_mon();
    do_req(3'd3, 2'd0, 0, 0, 0, k);
    lit("j pc_src", pw_src, 2);
    prev_pw = pw_cyc;
    do_req(3'd4, 2'd0, 0, 0, 0, k);
    lit("jr pc_src", pw_src, 3);
    lit("j-jr spacing", pw_cyc - prev_pw, 2);
    lit("j-jr pw count", pw_cnt, 2);

    // EXC cause 2 with three stall cycles and req/stall/zero noise.
    clr_mon();
    do_req(3'd5, 2'd2, 0, 3, 1, k);
    lit("exc epc_cyc", epc_cyc - k, 1);
    lit("exc mem_rd cycles", mr_cnt, 5);
    lit("exc vec_sel", mr_vs, 2);
    lit("exc pw_cyc", pw_cyc - k, 7);
    lit("exc pc_src", pw_src, 4);
    lit("exc done", done_cnt, 1);

    // Illegal op 7: opcode exception regardless of exc_cause.
    clr_mon();
    do_req(3'd7, 2'd3, 0, 0, 0, k);
    lit("op7 vec_sel", mr_vs, 0);
    lit("op7 mem_rd cycles", mr_cnt, 2);
    lit("op7 pw_cyc", pw_cyc - k, 4);

    // Branch with req toggling while busy.
    clr_mon();
    do_req(3'd2, 2'd0, 0, 0, 1, k);
    lit("bne noise done", done_cnt, 1);
    lit("bne noise pw", pw_cnt, 1);

    repeat (3) @(posedge clk);
    #1;
    lit("pending expectations", exp_q.num(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
